// File: rtl/simple_processor_pkg.sv
// Shared constants for the simple processor: instruction layout, opcodes,
// ALU operations, sequencing phases and the hard-coded program ROM.
package simple_processor_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned PC_W       = 4;
  localparam int unsigned DMEM_AW    = 4;
  localparam int unsigned DMEM_DEPTH = 16;
  localparam int unsigned PHASE_W    = 4;
  localparam int unsigned SLOT_LEN   = 16;
  localparam int unsigned WB_PHASE   = 7;
  localparam int unsigned STARTUP    = 2;
  localparam int unsigned STARTUP_W  = 2;
  localparam int unsigned IMM_W      = 17;

  // Field offsets (LSB positions) within an instruction word
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned SHAMT_LSB  = 7;
  localparam int unsigned ALUOP_LSB  = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  // Instruction word layout; imm[16:0] overlays rt/shamt/aluop/pad
  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] shamt;
    logic [4:0] aluop;
    logic [1:0] pad;
  } instr_t;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] shamt,
                                        input logic [4:0] aluop);
    return {OP_RTYPE, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Program ROM; address 15 is left as 0 (executes as nop)
  function automatic logic [31:0] rom_word(input logic [PC_W-1:0] addr);
    logic [31:0] w;
    w = '0;
    case (addr)
      4'd0:  w = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd5);
      4'd1:  w = enc_i(OP_ADDI, 5'd2, 5'd0, 17'd3);
      4'd2:  w = enc_r(5'd3, 5'd1, 5'd2, 5'd0, ALU_ADD);
      4'd3:  w = enc_r(5'd4, 5'd1, 5'd2, 5'd0, ALU_SUB);
      4'd4:  w = enc_r(5'd5, 5'd3, 5'd2, 5'd0, ALU_AND);
      4'd5:  w = enc_r(5'd6, 5'd0, 5'd2, 5'd1, ALU_SRA);
      4'd6:  w = enc_r(5'd7, 5'd5, 5'd2, 5'd0, ALU_OR);
      4'd7:  w = enc_r(5'd8, 5'd0, 5'd1, 5'd2, ALU_SLL);
      4'd8:  w = enc_r(5'd9, 5'd0, 5'd3, 5'd1, ALU_SRA);
      4'd9:  w = enc_i(OP_ADDI, 5'd10, 5'd0, 17'd345);
      4'd10: w = enc_i(OP_ADDI, 5'd11, 5'd0, 17'd567);
      4'd11: w = enc_i(OP_SW, 5'd10, 5'd0, 17'd0);
      4'd12: w = enc_i(OP_SW, 5'd11, 5'd0, 17'd1);
      4'd13: w = enc_i(OP_LW, 5'd12, 5'd0, 17'd0);
      4'd14: w = enc_i(OP_LW, 5'd13, 5'd0, 17'd1);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/simple_processor_skeleton_regfile.sv
// 32x32 register file: two async read ports, one write port, $0 reads as
// zero and ignores writes, async active-low clear.
// Ports: clock, clear_n, we/waddr/wdata (write), raddr_a/rdata_a,
// raddr_b/rdata_b (reads).
module regfile
  import simple_processor_pkg::*;
(
  input  logic              clock,
  input  logic              clear_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage with whole-array async clear
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/simple_processor_skeleton.sv
// Demo single-issue 32-bit core: ROM program, 16-word dmem, 32x32 regfile,
// one instruction per 16-cycle slot after a 2-cycle startup.
// Ports: clock, ctrl_reset (async active-low); derived clocks imem/dmem/
// regfile_clock (= clock) and processor_clock (high in phases 8-15);
// registered observation outputs for regfile ports, memories and writeback.
module simple_processor_skeleton
  import simple_processor_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  output logic              imem_clock,
  output logic              dmem_clock,
  output logic              regfile_clock,
  output logic              processor_clock,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic [DATA_W-1:0] q_dmem,
  output logic [DATA_W-1:0] q_imem,
  output logic [REG_AW-1:0] ctrl_writeReg,
  output logic [REG_AW-1:0] ctrl_readRegA,
  output logic [REG_AW-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_writeReg
);

  logic [PC_W-1:0]      pc;
  logic [PHASE_W-1:0]   phase;
  logic [STARTUP_W-1:0] startup;
  logic                 running;
  logic                 wb_edge;

  logic [DATA_W-1:0]  dmem [DMEM_DEPTH];
  logic [DMEM_AW-1:0] ea_q;
  logic [DATA_W-1:0]  wb_q;

  instr_t             instr;
  logic [DATA_W-1:0]  imm_ext;
  logic               is_r, is_addi, is_sw, is_lw, writes_rd;
  logic               early;
  logic [REG_AW-1:0]  ra, rb;
  logic [DATA_W-1:0]  rdata_a, rdata_b;
  logic [DATA_W-1:0]  alu_res, wb_now, wb_data, dmem_q;
  logic [DMEM_AW-1:0] ea_now, mem_addr;

  assign imem_clock      = clock;
  assign dmem_clock      = clock;
  assign regfile_clock   = clock;
  assign processor_clock = phase[PHASE_W-1];

  assign running = (startup == STARTUP_W'(STARTUP));
  assign wb_edge = running && (phase == PHASE_W'(WB_PHASE));
  assign early   = ~phase[PHASE_W-1];

  // Decode
  assign instr   = instr_t'(rom_word(pc));
  assign imm_ext = {{(DATA_W-IMM_W){instr.rt[4]}}, instr.rt, instr.shamt, instr.aluop, instr.pad};
  assign is_r    = (instr.opcode == OP_RTYPE);
  assign is_addi = (instr.opcode == OP_ADDI);
  assign is_sw   = (instr.opcode == OP_SW);
  assign is_lw   = (instr.opcode == OP_LW);

  // Port muxing: operands in the first half, A=$0/B=rd in the second half
  assign ra = early ? instr.rs : '0;
  assign rb = early ? (is_sw ? instr.rd : instr.rt) : instr.rd;

  regfile u_regfile (
    .clock   (clock),
    .clear_n (ctrl_reset),
    .we      (wb_edge && writes_rd),
    .waddr   (instr.rd),
    .wdata   (wb_now),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // ALU and writeback selection
  always_comb begin
    alu_res   = '0;
    writes_rd = 1'b0;
    if (is_r) begin
      writes_rd = 1'b1;
      case (instr.aluop)
        ALU_ADD: alu_res = rdata_a + rdata_b;
        ALU_SUB: alu_res = rdata_a - rdata_b;
        ALU_AND: alu_res = rdata_a & rdata_b;
        ALU_OR:  alu_res = rdata_a | rdata_b;
        ALU_SLL: alu_res = rdata_b << instr.shamt;
        ALU_SRA: alu_res = DATA_W'($signed(rdata_b) >>> instr.shamt);
        default: writes_rd = 1'b0;
      endcase
    end else if (is_addi) begin
      alu_res   = rdata_a + imm_ext;
      writes_rd = 1'b1;
    end else if (is_lw) begin
      writes_rd = 1'b1;
    end
  end

  // Port A is forced to $0 after writeback, so the address is held in ea_q
  assign ea_now   = DMEM_AW'(rdata_a + imm_ext);
  assign mem_addr = early ? ea_now : ea_q;
  assign dmem_q   = dmem[mem_addr];
  assign wb_now   = is_lw ? dmem[ea_now] : alu_res;
  assign wb_data  = early ? wb_now : wb_q;

  // Startup counter, phase counter and PC
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      startup <= '0;
      phase   <= '0;
      pc      <= '0;
    end else if (!running) begin
      startup <= startup + STARTUP_W'(1);
    end else begin
      phase <= phase + PHASE_W'(1);
      if (phase == PHASE_W'(SLOT_LEN - 1)) pc <= pc + PC_W'(1);
    end
  end

  // Data memory and writeback-time captures
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem[i] <= '0;
      ea_q <= '0;
      wb_q <= '0;
    end else if (wb_edge) begin
      if (is_sw) dmem[ea_now] <= rdata_b;
      ea_q <= ea_now;
      wb_q <= wb_now;
    end
  end

  // Registered observation outputs
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      data_readRegA <= '0;
      data_readRegB <= '0;
      q_dmem        <= '0;
      q_imem        <= '0;
      ctrl_writeReg <= '0;
      ctrl_readRegA <= '0;
      ctrl_readRegB <= '0;
      data_writeReg <= '0;
    end else begin
      data_readRegA <= rdata_a;
      data_readRegB <= rdata_b;
      q_dmem        <= dmem_q;
      q_imem        <= instr;
      ctrl_writeReg <= writes_rd ? instr.rd : '0;
      ctrl_readRegA <= ra;
      ctrl_readRegB <= rb;
      data_writeReg <= writes_rd ? wb_data : '0;
    end
  end

endmodule

// File: tb/tb_simple_processor_skeleton.sv
// Directed bench for simple_processor_skeleton: reset values, per-slot
// writeback results, mid-slot reset/restart and derived clock behaviour.
module tb_simple_processor_skeleton;

  logic        clock;
  logic        ctrl_reset;
  logic        imem_clock, dmem_clock, regfile_clock, processor_clock;
  logic [31:0] data_readRegA, data_readRegB, q_dmem, q_imem, data_writeReg;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;

  int n_checks;
  int n_fail;
  int cyc;

  simple_processor_skeleton dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .regfile_clock   (regfile_clock),
    .processor_clock (processor_clock),
    .data_readRegA   (data_readRegA),
    .data_readRegB   (data_readRegB),
    .q_dmem          (q_dmem),
    .q_imem          (q_imem),
    .ctrl_writeReg   (ctrl_writeReg),
    .ctrl_readRegA   (ctrl_readRegA),
    .ctrl_readRegB   (ctrl_readRegB),
    .data_writeReg   (data_writeReg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after posedge n (counted from reset release)
  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rega"},  data_readRegA, 32'd0);
    check({tag, "_regb"},  data_readRegB, 32'd0);
    check({tag, "_qdmem"}, q_dmem, 32'd0);
    check({tag, "_qimem"}, q_imem, 32'd0);
    check({tag, "_wdata"}, data_writeReg, 32'd0);
    check({tag, "_wreg"},  32'(ctrl_writeReg), 32'd0);
    check({tag, "_ra"},    32'(ctrl_readRegA), 32'd0);
    check({tag, "_rb"},    32'(ctrl_readRegB), 32'd0);
  endtask

  logic [31:0] exp_b [16];
  int highs, rises, last_rise, period;
  logic prev_pc;

  initial begin
    exp_b = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd0, 32'd1, 32'd3, 32'd20,
              32'd4, 32'd345, 32'd567, 32'd345, 32'd567, 32'd345, 32'd567, 32'd0};
    n_checks = 0;
    n_fail = 0;
    cyc = 0;

    // Power-on reset held for 4 cycles
    ctrl_reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check_all_zero("reset");
    check("reset_pclk", 32'(processor_clock), 32'd0);

    @(negedge clock);
    ctrl_reset = 1'b1;
    cyc = 0;

    // Slots 0..16 (second pass of slot 0 at k=16)
    for (int k = 0; k < 17; k++) begin
      if (k == 2) begin
        for (int j = 0; j < 8; j++) begin
          run_to(35 + j);
          check("s2_ra", 32'(ctrl_readRegA), 32'd1);
          check("s2_rb", 32'(ctrl_readRegB), 32'd2);
          check("s2_wdata", data_writeReg, 32'd8);
          check("s2_wreg", 32'(ctrl_writeReg), 32'd3);
        end
      end
      run_to(18 + 16 * k);
      check($sformatf("slot%0d_rega", k), data_readRegA, 32'd0);
      check($sformatf("slot%0d_regb", k), data_readRegB, exp_b[k % 16]);
      if (k == 13 || k == 14)
        check($sformatf("slot%0d_qdmem", k), q_dmem, exp_b[k]);
      if (k == 15)
        check("slot15_wreg", 32'(ctrl_writeReg), 32'd0);
    end

    // processor_clock: 16-cycle period, 8 cycles high
    highs = 0;
    rises = 0;
    last_rise = -1;
    period = 0;
    prev_pc = processor_clock;
    for (int i = 0; i < 32; i++) begin
      @(posedge clock);
      cyc++;
      #1;
      if (processor_clock) highs++;
      if (processor_clock && !prev_pc) begin
        rises++;
        if (last_rise >= 0) period = i - last_rise;
        last_rise = i;
      end
      prev_pc = processor_clock;
    end
    check("pclk_high", 32'(highs), 32'd16);
    check("pclk_rises", 32'(rises), 32'd2);
    check("pclk_period", 32'(period), 32'd16);

    // Pass-through clocks follow clock at both levels
    check("imem_clk_hi", 32'(imem_clock), 32'd1);
    check("dmem_clk_hi", 32'(dmem_clock), 32'd1);
    check("rf_clk_hi", 32'(regfile_clock), 32'd1);
    @(negedge clock);
    #1;
    check("imem_clk_lo", 32'(imem_clock), 32'd0);
    check("dmem_clk_lo", 32'(dmem_clock), 32'd0);
    check("rf_clk_lo", 32'(regfile_clock), 32'd0);

    // Fresh restart, then reset at phase 3 of slot 2
    ctrl_reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    ctrl_reset = 1'b1;
    cyc = 0;
    run_to(37);
    ctrl_reset = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) @(posedge clock);
    @(negedge clock);
    ctrl_reset = 1'b1;
    cyc = 0;
    run_to(18);
    check("restart_slot0", data_readRegB, 32'd5);
    run_to(34);
    check("restart_slot1", data_readRegB, 32'd3);
    run_to(50);
    check("restart_slot2", data_readRegB, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_processor_skeleton.md
# simple_processor_skeleton

Self-contained demo core: a 32-bit, single-issue processor with a hard-coded 16-word instruction ROM, a 16-word data RAM and a 32×32 register file. It executes one instruction every 16 `clock` cycles. Its register-file read ports, memory outputs and derived clocks are exported for bench observation. It is the top of the simple-processor exercise; nothing instantiates it except the bench.

## Interface
- No parameters. Constants are in the package.
- `clock` in 1: sole clock, rising-edge.
- `ctrl_reset` in 1: asynchronous, active-low reset.
- `imem_clock` out 1: equals `clock`.
- `dmem_clock` out 1: equals `clock`.
- `regfile_clock` out 1: equals `clock`.
- `processor_clock` out 1: high during phases 8–15, low otherwise.
- `data_readRegA` out 32: regfile port A data.
- `data_readRegB` out 32: regfile port B data.
- `q_dmem` out 32: dmem word at the current instruction's address.
- `q_imem` out 32: current instruction word.
- `ctrl_writeReg` out 5: writeback register of the current instruction.
- `ctrl_readRegA` out 5: port A address.
- `ctrl_readRegB` out 5: port B address.
- `data_writeReg` out 32: writeback data of the current instruction.

## Operation
- Instruction format:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2].
  - imm [16:0] is sign-extended to 32 bits.
- R-type (opcode 00000), selected by aluop:
  - 00000 add, 00001 sub, 00010 and, 00011 or.
  - 00100 sll rt by shamt; 00101 sra rt by shamt.
- Other opcodes:
  - 00101 addi: rd = rs + imm.
  - 00111 sw: dmem[rs+imm] = rd.
  - 01000 lw: rd = dmem[rs+imm].
- Unknown opcodes execute as nop.
- Arithmetic is 32-bit two's complement with wrap; no overflow flag.
- Memory addressing: dmem address is (rs+imm)[3:0].
- Writes to $0 are discarded; $0 always reads 0.
- ROM program (addresses 0–14; 15 holds 0, which executes as nop):
  - 0–3: addi $1,$0,5; addi $2,$0,3; add $3,$1,$2; sub $4,$1,$2.
  - 4–6: and $5,$3,$2; sra $6,$2,1; or $7,$5,$2.
  - 7–10: sll $8,$1,2; sra $9,$3,1; addi $10,$0,345; addi $11,$0,567.
  - 11–14: sw $10,0($0); sw $11,1($0); lw $12,0($0); lw $13,1($0).
- PC is 4 bits and wraps 15→0. Re-execution reproduces the same values.
- Read-port muxing:
  - Phases 0–7: A=rs, B=rt (for sw, B=rd).
  - Phases 8–15: A=$0, B=rd.

## Timing
- Reset (ctrl_reset=0), immediate:
  - PC, phase counter and startup counter are 0.
  - All registers and all dmem words are 0.
  - Every output except the derived clocks is 0.
- After reset release, two startup cycles elapse; posedges 1–2 fetch instruction 0.
- Slot k spans posedges 3+16k … 18+16k. The phase counter runs 0–15.
- Regfile/dmem write occurs on the posedge ending phase 7. From phase 8, B shows the new value.
- PC increments on the posedge ending phase 15.
- After posedge 18+16k, outputs show A=0 and B = slot k result. This stays stable until posedge 19+16k.
- Async reset mid-slot aborts the instruction with no partial write.

## Structure
- Package `simple_processor_pkg`:
  - opcode/aluop constants and field offsets.
  - the ROM contents, and phase constants (WB_PHASE=7, SLOT_LEN=16, STARTUP=2).
- Sub-module `regfile`: 32×32, two async read ports, one write port, $0 hardwired to zero, async active-low clear.
- ALU, ROM, dmem and the phase sequencer stay in the top.

## Test plan
- Reset held 4 cycles, released at negedge → all non-clock outputs are 0 during reset.
- Sample after posedge 18+16k, k=0..12 → data_readRegA=0 and data_readRegB = 5,3,8,2,0,1,3,20,4,345,567,345,567.
- Slots 13 and 14 → B=345 and 567 (lw readback); q_dmem matches.
- Reset asserted at phase 3 of slot 2 → $3 stays 0; after re-release the program restarts and k=0 yields 5.
- Writeback checks:
  - Instruction with rd=$0 (ROM slot 15 nop) → $0 remains 0.
  - During phases 0–7 of slot 2 → ctrl_readRegA=1, ctrl_readRegB=2, data_writeReg=8, ctrl_writeReg=3.
- processor_clock period = 16 clock cycles with 50% duty; the other three derived clocks track `clock`.
